csram_sweep_ctrl: RTL and testbench

Sequencer and arbiter for one core's neuron configuration/state SRAM (CSRAM). On each tick it walks neuron addresses 0..NUM_NEURONS-1, reads each entry, presents it to the neuron block, and writes back the updated membrane potential field with a read-modify-write. Between sweeps it grants single-entry configuration writes from the loader. It is the only master of the CSRAM port; the CSRAM captures address, wen and data on the falling edge of the same clk.

---
 rtl/csram_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_csram_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/csram_sweep_ctrl.sv
// Sole master of one core's CSRAM port: per tick it sweeps every neuron entry through
// read / present / potential write-back, and grants loader config writes while idle.
module csram_sweep_ctrl #(
  parameter int NUM_NEURONS = 256,
  parameter int WIDTH       = 367,
  parameter int WRITE_INDEX = 102,
  parameter int WRITE_WIDTH = 9,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  output logic                   busy,
  output logic                   done,
  output logic                   tick_overrun,
  output logic                   neuron_valid,
  input  logic                   neuron_ready,
  output logic [AW-1:0]          neuron_addr,
  output logic [WIDTH-1:0]       neuron_data,
  input  logic [WRITE_WIDTH-1:0] pot_value,
  input  logic                   cfg_req,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [WIDTH-1:0]       cfg_data,
  output logic                   cfg_gnt,
  output logic                   csram_wen,
  output logic [AW-1:0]          csram_address,
  output logic [WIDTH-1:0]       csram_data_in,
  input  logic [WIDTH-1:0]       csram_data_out
);

  typedef enum logic [2:0] {IDLE, CFG, READ, PRESENT, WRITE, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

  state_t                 state, state_nxt;
  logic [AW-1:0]          n;
  logic [AW-1:0]          cfg_addr_q;
  logic [WIDTH-1:0]       cfg_data_q;
  logic [WIDTH-1:0]       hold;
  logic [WRITE_WIDTH-1:0] pot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n          <= '0;
      hold       <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      pot_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // a same-cycle tick takes priority; the request stays pending until after the sweep
        IDLE:    if (!tick && cfg_req) begin
                   cfg_addr_q <= cfg_addr;
                   cfg_data_q <= cfg_data;
                 end
        READ:    hold <= csram_data_out;
        PRESENT: if (neuron_ready) pot_q <= pot_value;
        WRITE:   if (n != LAST) n <= n + 1'b1;
        DONE:    n <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    tick_overrun  = tick && (state != IDLE);
    neuron_valid  = 1'b0;
    neuron_addr   = '0;
    neuron_data   = '0;
    cfg_gnt       = 1'b0;
    csram_wen     = 1'b0;
    csram_address = '0;
    csram_data_in = '0;
    case (state)
      IDLE: begin
        if (tick)         state_nxt = READ;
        else if (cfg_req) state_nxt = CFG;
      end
      CFG: begin
        csram_wen     = 1'b1;
        csram_address = cfg_addr_q;
        csram_data_in = cfg_data_q;
        cfg_gnt       = 1'b1;
        state_nxt     = IDLE;
      end
      READ: begin
        csram_address = n;
        state_nxt     = PRESENT;
      end
      PRESENT: begin
        csram_address = n;
        neuron_valid  = 1'b1;
        neuron_addr   = n;
        neuron_data   = hold;
        if (neuron_ready) state_nxt = WRITE;
      end
      WRITE: begin
        // read-modify-write: only the potential field changes
        csram_wen     = 1'b1;
        csram_address = n;
        csram_data_in = hold;
        csram_data_in[WRITE_INDEX +: WRITE_WIDTH] = pot_q;
        state_nxt     = (n == LAST) ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csram_sweep_ctrl.sv
// Bench for csram_sweep_ctrl: CSRAM model on the falling edge, array reference model of
// entry contents, handshake log checked for order, data and stall stability.
module tb_csram_sweep_ctrl;
  localparam int N = 256, WIDTH = 367, WI = 102, WW = 9, AW = 8;

  logic clk = 0, rst = 1, tick = 0;
  logic busy, done, tick_overrun, neuron_valid, neuron_ready = 0, cfg_req = 0, cfg_gnt;
  logic [AW-1:0] neuron_addr, cfg_addr = 0, csram_address;
  logic [WIDTH-1:0] neuron_data, cfg_data = 0, csram_data_in, csram_data_out;
  logic csram_wen;
  logic [WW-1:0] pot_value;
  logic [WW-1:0] pot_tab [N];

  logic [WIDTH-1:0] mem [N];
  logic [WIDTH-1:0] ref_mem [N];

  // small instance for the wrap check
  logic tick4 = 0, busy4, done4, ovr4, valid4, gnt4, wen4;
  logic [1:0] addr4, a4;
  logic [WIDTH-1:0] data4, din4, dout4;
  logic [WIDTH-1:0] mem4 [4];

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, gnt_cnt = 0, ovr_cnt = 0, unstable = 0, done4_cnt = 0;
  int pres_addr [$];
  logic [WIDTH-1:0] pres_data [$];
  int pres4 [$];
  logic stall_q = 0;
  logic [AW-1:0] addr_q;
  logic [WIDTH-1:0] data_q;

  always #5 clk = ~clk;
  assign pot_value = pot_tab[neuron_addr];

  csram_sweep_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .busy(busy), .done(done), .tick_overrun(tick_overrun),
    .neuron_valid(neuron_valid), .neuron_ready(neuron_ready), .neuron_addr(neuron_addr),
    .neuron_data(neuron_data), .pot_value(pot_value), .cfg_req(cfg_req), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_gnt(cfg_gnt), .csram_wen(csram_wen), .csram_address(csram_address),
    .csram_data_in(csram_data_in), .csram_data_out(csram_data_out));

  csram_sweep_ctrl #(.NUM_NEURONS(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick4), .busy(busy4), .done(done4), .tick_overrun(ovr4),
    .neuron_valid(valid4), .neuron_ready(1'b1), .neuron_addr(addr4), .neuron_data(data4),
    .pot_value(9'd0), .cfg_req(1'b0), .cfg_addr(2'd0), .cfg_data('0), .cfg_gnt(gnt4),
    .csram_wen(wen4), .csram_address(a4), .csram_data_in(din4), .csram_data_out(dout4));

  always @(negedge clk) begin
    csram_data_out <= mem[csram_address];
    if (csram_wen) mem[csram_address] <= csram_data_in;
    dout4 <= mem4[a4];
    if (wen4) mem4[a4] <= din4;
  end

  always @(posedge clk) begin
    if (stall_q && !rst && (neuron_addr !== addr_q || neuron_data !== data_q)) unstable <= unstable + 1;
    stall_q <= neuron_valid && !neuron_ready && !rst;
    addr_q  <= neuron_addr;
    data_q  <= neuron_data;
    if (neuron_valid && neuron_ready) begin
      pres_addr.push_back(int'(neuron_addr));
      pres_data.push_back(neuron_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (cfg_gnt) gnt_cnt <= gnt_cnt + 1;
    if (tick_overrun) ovr_cnt <= ovr_cnt + 1;
    if (valid4) pres4.push_back(int'(addr4));
    if (done4) done4_cnt <= done4_cnt + 1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);          chk({tag, "_done"}, done, 0);
    chk({tag, "_ovr"}, tick_overrun, 0);   chk({tag, "_valid"}, neuron_valid, 0);
    chk({tag, "_naddr"}, neuron_addr, 0);  chk({tag, "_ndata"}, neuron_data, 0);
    chk({tag, "_gnt"}, cfg_gnt, 0);        chk({tag, "_wen"}, csram_wen, 0);
    chk({tag, "_caddr"}, csram_address, 0); chk({tag, "_cdin"}, csram_data_in, 0);
  endtask

  function automatic logic [WIDTH-1:0] rand_entry();
    logic [WIDTH-1:0] v = '0;
    for (int i = 0; i < 12; i++) v = (v << 32) | WIDTH'($urandom);
    return v;
  endfunction

  task automatic cfg_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    cfg_req = 1; cfg_addr = a; cfg_data = d;
    step();
    chk("cfg_gnt", cfg_gnt, 1); chk("cfg_wen", csram_wen, 1);
    chk("cfg_addr", csram_address, a); chk("cfg_data", csram_data_in, d);
    cfg_req = 0;
    step();
    chk("cfg_gnt_pulse", cfg_gnt, 0);
    ref_mem[a] = d;
  endtask

  // one sweep from IDLE; optional random ready and an extra tick at neuron ov_at
  task automatic run_sweep(input bit rnd, input int ov_at, output int cyc);
    bit ov_done = 0;
    int guard = 0;
    pres_addr.delete(); pres_data.delete();
    tick = 1; step(); tick = 0; cyc = 0;
    while (done !== 1'b1 && guard < 5000) begin
      neuron_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!ov_done && neuron_valid && int'(neuron_addr) == ov_at) begin
        tick = 1; #1;
        chk("tick_overrun_flag", tick_overrun, 1);
        ov_done = 1;
      end
      step(); tick = 0; cyc++; guard++;
    end
    neuron_ready = 0;
    chk("sweep_timeout", guard < 5000, 1);
  endtask

  // presented entries must be 0..N-1 once each, carrying the pre-sweep contents
  task automatic chk_pres(input string tag);
    int bad = 0;
    chk({tag, "_count"}, pres_addr.size(), N);
    foreach (pres_addr[i]) if (pres_addr[i] != i || pres_data[i] !== ref_mem[i]) bad++;
    chk({tag, "_order_data"}, bad, 0);
  endtask

  task automatic apply_pots(input int upto);
    for (int i = 0; i < upto; i++) ref_mem[i][WI +: WW] = pot_tab[i];
  endtask

  task automatic chk_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    int cyc, d0, g0, o0, u0, guard;
    logic [WIDTH-1:0] d9;
    for (int i = 0; i < N; i++) begin mem[i] = '0; ref_mem[i] = '0; pot_tab[i] = WW'(i); end
    for (int i = 0; i < 4; i++) mem4[i] = '0;

    step(); step();
    chk_zero("reset");
    rst = 0;
    step();
    chk_zero("idle");

    // entry 5 all-ones, then distinct patterns elsewhere
    cfg_write(8'd5, '1);
    for (int i = 0; i < N; i++) if (i != 5) cfg_write(AW'(i), rand_entry());
    chk_mem("preload_mem");

    // full-speed sweep with pot = n
    d0 = done_cnt;
    run_sweep(0, -1, cyc);
    chk("sweep_latency", cyc, 768);
    chk_pres("sweep1");
    chk("entry5_all_ones", pres_data.size() > 5 ? pres_data[5] : '0, '1);
    step();
    chk("done_pulse_width", done, 0);
    chk("busy_after_done", busy, 0);
    chk("done_count1", done_cnt - d0, 1);
    apply_pots(N);
    chk_mem("sweep1_mem");

    // random stalls, tick+cfg_req together, extra tick at neuron 100
    for (int i = 0; i < N; i++) pot_tab[i] = WW'($urandom);
    d9 = rand_entry();
    cfg_req = 1; cfg_addr = 8'd9; cfg_data = d9;
    d0 = done_cnt; g0 = gnt_cnt; o0 = ovr_cnt; u0 = unstable;
    run_sweep(1, 100, cyc);
    chk_pres("sweep2");
    chk("stall_stable", unstable - u0, 0);
    chk("overrun_once", ovr_cnt - o0, 1);
    chk("gnt_during_sweep", gnt_cnt - g0, 0);
    step();
    chk("gnt_idle_after_done", cfg_gnt, 0);
    chk("done_count2", done_cnt - d0, 1);
    step();
    chk("gnt_after_sweep", cfg_gnt, 1);
    chk("gnt_after_sweep_addr", csram_address, 9);
    cfg_req = 0;
    step();
    chk("gnt_single", gnt_cnt - g0, 1);
    apply_pots(N);
    ref_mem[9] = d9;
    chk_mem("sweep2_mem");

    // reset while presenting neuron 37
    for (int i = 0; i < N; i++) pot_tab[i] = WW'($urandom);
    tick = 1; step(); tick = 0; neuron_ready = 1; guard = 0;
    while (!(neuron_valid && neuron_addr == 8'd37) && guard < 500) begin step(); guard++; end
    neuron_ready = 0;
    chk("reach_37_timeout", guard < 500, 1);
    step(); step();
    d0 = done_cnt;
    rst = 1;
    step();
    chk_zero("mid_rst");
    rst = 0;
    step();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    apply_pots(37);
    chk_mem("mid_rst_mem");
    run_sweep(0, -1, cyc);
    chk("restart_first_addr", pres_addr.size() > 0 ? pres_addr[0] : -1, 0);
    chk_pres("sweep3");
    apply_pots(N);
    step(); step();
    chk_mem("sweep3_mem");

    // four-neuron instance: two sweeps, address must wrap to 0
    for (int s = 0; s < 2; s++) begin
      d0 = done4_cnt;
      tick4 = 1; step(); tick4 = 0; guard = 0;
      while (done4_cnt == d0 && guard < 100) begin step(); guard++; end
      chk("n4_timeout", guard < 100, 1);
    end
    step();
    chk("n4_done_count", done4_cnt, 2);
    chk("n4_seq_len", pres4.size(), 8);
    for (int i = 0; i < 8 && i < pres4.size(); i++) chk("n4_addr", pres4[i], i % 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
